// File: rtl/cp0_register_file_if.sv
// cp0_register_file_if: CP0 submission bus between the submitter (master) and the register file (slave)
interface cp0_register_file_if;
  logic [5:0]  HWInt;
  logic [5:0]  interrupt_request;
  logic [31:0] new_SR;
  logic        SR_enable;
  logic [31:0] new_Cause;
  logic        Cause_enable;
  logic [31:0] new_EPC;
  logic        EPC_enable;
  logic [4:0]  read_address;
  logic [31:0] read_data;
  logic [31:0] current_SR;
  logic [31:0] current_EPC;
  modport master (
    output HWInt, new_SR, SR_enable, new_Cause, Cause_enable, new_EPC, EPC_enable, read_address,
    input  interrupt_request, read_data, current_SR, current_EPC
  );
  modport slave (
    input  HWInt, new_SR, SR_enable, new_Cause, Cause_enable, new_EPC, EPC_enable, read_address,
    output interrupt_request, read_data, current_SR, current_EPC
  );
endinterface

// File: rtl/cp0_register_file.sv
// cp0_register_file: SR/Cause/EPC state with hardware interrupt sampling and mfc0 read port
module cp0_register_file #(
  parameter logic [31:0] PRID         = 32'h0000_5217,
  parameter bit          WRITE_BYPASS = 1'b1
) (
  input logic clk,
  input logic reset,
  cp0_register_file_if.slave bus
);
  localparam logic [31:0] SR_MASK    = 32'h0000_FC03;
  localparam logic [31:0] CAUSE_MASK = 32'h8000_007C;
  logic [31:0] sr, cause_w, epc, cause, ip_field, sr_rd, cause_rd, epc_rd;
  logic [5:0]  ip;
  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      cause_w <= '0;
      epc     <= '0;
      ip      <= '0;
    end else begin
      ip <= bus.HWInt;
      if (bus.SR_enable) sr <= bus.new_SR & SR_MASK;
      if (bus.Cause_enable) cause_w <= bus.new_Cause & CAUSE_MASK;
      if (bus.EPC_enable) epc <= bus.new_EPC;
    end
  end
  assign ip_field = {16'h0, ip, 10'h0};
  assign cause    = cause_w | ip_field;
  // bypass is suppressed under reset so reads show the registered state
  always_comb begin
    sr_rd    = (WRITE_BYPASS && !reset && bus.SR_enable) ? bus.new_SR & SR_MASK : sr;
    cause_rd = (WRITE_BYPASS && !reset && bus.Cause_enable) ? (bus.new_Cause & CAUSE_MASK) | ip_field : cause;
    epc_rd   = (WRITE_BYPASS && !reset && bus.EPC_enable) ? bus.new_EPC : epc;
    bus.read_data = bus.read_address == 5'd12 ? sr_rd :
                    bus.read_address == 5'd13 ? cause_rd :
                    bus.read_address == 5'd14 ? epc_rd :
                    bus.read_address == 5'd15 ? PRID : 32'h0;
  end
  assign bus.current_SR        = sr;
  assign bus.current_EPC       = epc;
  assign bus.interrupt_request = ip;
endmodule
